// File: rtl/lsu_pkg.sv
// Shared state encodings, funct3 size codes and bus widths for the load/store bridge
// and its byte-enable/alignment helper.
package lsu_pkg;

   localparam int LSU_ADDR_W = 32;
   localparam int LSU_DATA_W = 32;
   localparam int LSU_BE_W   = LSU_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_byte_en.sv
// Byte-enable and alignment decode for one RV32I memory access; purely combinational
// so the fetch-side alignment checker can share it.
module lsu_byte_en
   import lsu_pkg::*;
(
   input  logic [2:0]          funct3,
   input  logic [1:0]          addr_lo,
   input  logic                we,
   output logic [LSU_BE_W-1:0] be,
   output logic                misalign_cond
);

   // Loads always fetch the whole word; funct3 codes that name no access size are
   // flagged like a misalignment so they never reach the bus.
   always_comb begin
      be            = 4'b1111;
      misalign_cond = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            if (we) be = 4'b0001 << addr_lo;
         end
         F3_H, F3_HU: begin
            misalign_cond = addr_lo[0];
            if (we) be = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         F3_W: begin
            misalign_cond = |addr_lo;
         end
         default: begin
            misalign_cond = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the single-cycle RV32I datapath and a valid/ready data bus.
// Optional watchdog on stuck transactions: define LSU_BRIDGE_TIMEOUT_EN.
module lsu_bus_bridge
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic              mem_we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              misaligned,
   output logic              fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_err
);

   lsu_state_t  state;
   logic [3:0]  be_calc;
   logic        misalign_cond;
   logic        timed_out;

   lsu_byte_en u_byte_en (
      .funct3        (funct3),
      .addr_lo       (addr[1:0]),
      .we            (mem_we),
      .be            (be_calc),
      .misalign_cond (misalign_cond)
   );

   // Dropping stall in DONE lets the core retire the instruction that owned the access.
   assign stall = mem_valid & ~misalign_cond & (state != DONE);

`ifdef LSU_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] tmo_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (state == REQ || state == WAIT) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign timed_out = (state == REQ || state == WAIT) &&
                      (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   logic [7:0] unused_timeout_cyc;

   assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
   assign timed_out          = 1'b0;
`endif

   // Bus-side outputs are latched on acceptance and stay frozen until the grant;
   // inputs from the core are not looked at again until the FSM is back in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         bus_be     <= 4'b0000;
         rdata      <= '0;
         misaligned <= 1'b0;
         fault      <= 1'b0;
      end else begin
         misaligned <= 1'b0;
         fault      <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_valid) begin
                  if (misalign_cond) begin
                     misaligned <= 1'b1;
                  end else begin
                     bus_we    <= mem_we;
                     bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     bus_wdata <= wdata;
                     bus_be    <= be_calc;
                     bus_req   <= 1'b1;
                     state     <= REQ;
                  end
               end
            end
            REQ: begin
               if (bus_gnt) begin
                  bus_req <= 1'b0;
                  if (bus_rvalid) begin
                     if (!bus_we) rdata <= bus_rdata;
                     fault <= bus_err;
                     state <= DONE;
                  end else begin
                     state <= WAIT;
                  end
               end else if (timed_out) begin
                  bus_req <= 1'b0;
                  fault   <= 1'b1;
                  state   <= DONE;
               end
            end
            WAIT: begin
               if (bus_rvalid) begin
                  if (!bus_we) rdata <= bus_rdata;
                  fault <= bus_err;
                  state <= DONE;
               end else if (timed_out) begin
                  fault <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
Load/store bus bridge directly downstream of the single-cycle RV32I datapath's memory-side outputs: address (ALU result), store data, funct3 and memory-op control.
- Drives a valid/ready external data-memory bus and returns read data to the datapath's ReadData input.
- Asserts a stall so the core holds PC and the instruction while an access is in flight.
- Detects misaligned accesses and suppresses them.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 for RV32I, with 4 byte lanes.
- TIMEOUT_CYC, 255, watchdog limit, used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  current instruction is a load or store.
- mem_we  input  1  1 = store, 0 = load.
- funct3  input  3  instruction funct3 (size field).
- addr  input  ADDR_W  byte address from the ALU result.
- wdata  input  DATA_W  lane-aligned store data from the store formatter.
- rdata  output  DATA_W  registered read data to the datapath ReadData.
- stall  output  1  hold PC and instruction.
- misaligned  output  1  one-cycle pulse: access suppressed.
- fault  output  1  one-cycle pulse: bus error or timeout.
- bus_req  output  1  request valid.
- bus_we  output  1  write enable.
- bus_addr  output  ADDR_W  word address, low 2 bits forced to 0.
- bus_wdata  output  DATA_W  write data.
- bus_be  output  4  byte enables.
- bus_gnt  input  1  request accepted (ready).
- bus_rvalid  input  1  response valid; sent for both loads and stores.
- bus_rdata  input  DATA_W  response data.
- bus_err  input  1  response error, qualified by bus_rvalid.

Behaviour:
- Reset (async, active-high): state=IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, rdata, misaligned and fault all 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_valid & aligned → latch bus_we, bus_addr, bus_wdata, bus_be; go to REQ.
  - mem_valid & misaligned → pulse misaligned next cycle, no bus activity, stay IDLE.
- REQ: bus_req=1; all bus outputs stable until bus_gnt.
  - bus_gnt & bus_rvalid in the same cycle → DONE.
  - bus_gnt alone → WAIT.
- WAIT: bus_req=0; on bus_rvalid, capture bus_rdata into rdata (loads only) and capture bus_err; go to DONE.
- DONE: fault=captured err for this one cycle; then → IDLE.
- stall (combinational): mem_valid & ~misalign_cond & (state != DONE).
  - stall is low in DONE so the core retires the instruction.
  - A back-to-back memory instruction is accepted in the following IDLE cycle.
- Minimum latency: 2 stall cycles (IDLE, REQ with gnt+rvalid), retire in cycle 3 (DONE).
- Alignment rules:
  - LB, LBU, SB: always aligned.
  - LH, LHU, SH: addr[0]=0.
  - LW, SW: addr[1:0]=0.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: addr[1] ? 4'b1100 : 4'b0011.
  - SW: 4'b1111.
  - All loads: 4'b1111. The downstream load formatter extracts the lanes.
- rdata holds its value until the next load response; stores do not modify it.
- bus_rvalid outside REQ/WAIT (a stray or late response after reset) is ignored.
- A change of mem_valid while in REQ/WAIT is ignored; the in-flight access completes.
- Reset mid-access: bus_req drops immediately and the transaction is abandoned.
- bus_err on a load: rdata is still updated and fault is pulsed; trap handling belongs to the control unit.

Optional Feature:
- Macro: LSU_BRIDGE_TIMEOUT_EN.
- With it defined: an 8-bit or wider cycle counter clears on entering REQ and increments in REQ and WAIT. When it reaches TIMEOUT_CYC, the FSM goes to DONE with fault=1, bus_req drops, and rdata is unchanged.
- Without it: no counter; the bridge waits indefinitely for bus_gnt or bus_rvalid.

Decomposition:
- Shared package / header (lsu_pkg):
  - FSM state encodings: IDLE=0, REQ=1, WAIT=2, DONE=3.
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Bus width localparams.
- Sub-module: lsu_byte_en, a combinational block (funct3, addr[1:0], we → bus_be, misalign_cond), reused by the fetch-side alignment checker.

Test Plan:
- SW addr=0x0000_1004, wdata=0xDEADBEEF; gnt and rvalid in the same cycle → bus_be=1111, bus_addr=0x1004; stall high 2 cycles, low on cycle 3; fault=0.
- SB addr=0x0000_2003; gnt 3 cycles late, rvalid 2 cycles after that → bus_be=1000; bus_req stays high until gnt; stall low only in DONE.
- LW addr=0x100, bus_rdata=0x12345678 → rdata=0x12345678 in DONE; a following SH leaves rdata=0x12345678.
- LH addr=0x101 → misaligned pulse 1 cycle, bus_req never asserted, stall=0.
- LW with bus_err=1 on rvalid → fault pulses 1 cycle in DONE; FSM returns to IDLE. Reset asserted while in WAIT → bus_req=0 at once and state=IDLE; a later stray rvalid is ignored.
- With LSU_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=8, gnt never asserted → fault=1 after 8 cycles in REQ, then IDLE. Without the macro, stall stays high indefinitely.
